stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Minutes:seconds BCD stopwatch that consumes the one-cycle `Rollover` pulse of the upstream prescaling counter as its 1 Hz `Tick`. Debounced single-cycle button pulses drive a four-state controller (start/stop, lap-freeze, clear). The block presents four BCD digits to the display driver downstream. All time-keeping advances only on `Tick`; `Clock` is the fast system clock.

## Interface
- `MIN_MOD`, default 60: minutes modulus. Legal values are multiples of 10 in 10..100. The minutes field counts 0..MIN_MOD-1.
- `Clock`, in, 1: system clock, rising-edge.
- `Reset_n`, in, 1: asynchronous, active-low reset.
- `Tick`, in, 1: one-cycle pulse, one per second, from the upstream counter's `Rollover`.
- `Start_Stop`, in, 1: one-cycle debounced button pulse.
- `Lap`, in, 1: one-cycle debounced button pulse.
- `Clear`, in, 1: one-cycle debounced button pulse.
- `Sec_Ones`, out, 4: displayed seconds units, BCD 0..9.
- `Sec_Tens`, out, 4: displayed seconds tens, BCD 0..5.
- `Min_Ones`, out, 4: displayed minutes units, BCD 0..9.
- `Min_Tens`, out, 4: displayed minutes tens, BCD 0..(MIN_MOD/10-1).
- `Running`, out, 1: high in RUN and LAP.
- `Lap_Active`, out, 1: high in LAP (display frozen).
- `Wrap`, out, 1: one-cycle pulse when live time wraps from max to 00:00.

## Operation
- States:
  - IDLE: live time is zero.
  - RUN: counting; display shows live time.
  - LAP: counting; display shows latched lap time.
  - PAUSE: stopped; display shows live time.
- Input priority when pulses coincide: `Clear` > `Start_Stop` > `Lap`. Only the highest-priority pulse present acts.
- Transitions (unlisted inputs are ignored):
  - IDLE: `Start_Stop` → RUN.
  - RUN: `Start_Stop` → PAUSE; `Lap` → LAP, and live time is copied into the lap latch on the same edge.
  - LAP: `Lap` → RUN; `Start_Stop` → PAUSE, and the display returns to live time.
  - PAUSE: `Start_Stop` → RUN; `Clear` → IDLE, and live time and the lap latch are zeroed.
- Counting: on an edge where `Tick`=1 and the current state is RUN or LAP, live time increments by one second.
  - The decision uses the current registered state. A `Tick` coinciding with `Start_Stop` in RUN still counts; one coinciding with `Start_Stop` in PAUSE or IDLE does not.
- Lap latch and `Tick` on the same edge: the latch captures the pre-increment live value.
- Arithmetic is a BCD digit chain:
  - `Sec_Ones` 9→0 carries into `Sec_Tens`.
  - `Sec_Tens` 5→0 carries into `Min_Ones`.
  - `Min_Ones` 9→0 carries into `Min_Tens`.
  - `Min_Tens` at MIN_MOD/10-1 wraps to 0.
  - No digit ever holds a non-BCD value.
- Wrap: time (MIN_MOD-1):59 + `Tick` → 00:00. `Wrap` pulses high for exactly that one cycle, and counting continues.
- Display outputs are a combinational mux: lap latch when in LAP, live registers otherwise. They add no register stage.

## Timing
- Reset (asserted at any time, including mid-count or during LAP):
  - State → IDLE.
  - All digits, the lap latch, `Running`, `Lap_Active` and `Wrap` → 0.
  - Takes effect immediately and asynchronously; release is synchronous to `Clock`.
- `Tick` sampled at edge N: new live digits are visible after edge N, with zero added latency.
- A button pulse at edge N changes the state at edge N. `Running` and `Lap_Active` reflect the new state after edge N.
- `Wrap` is registered: high for the single cycle following the wrapping edge.
- `Tick` must not be high for two consecutive cycles. Behaviour with back-to-back `Tick` is still a defined +1 per asserted cycle.

## Structure
- Shared header `stopwatch_defs.vh`:
  - 2-bit state encodings: IDLE=0, RUN=1, LAP=2, PAUSE=3.
  - BCD digit width: 4.
  - Seconds-tens limit: 5.
- Sub-module `bcd_digit`:
  - Parameter: modulus.
  - Ports: `Clock`, `Reset_n`, `Inc`, `Clr`; outputs `Digit[3:0]` and a combinational `Carry` (= `Inc` && at max).
  - Instantiated four times and chained by `Carry`→`Inc`.
- The top level holds the FSM, the lap latch (16 bits) and the display mux.

## Test plan
- Reset, then `Start_Stop`, then 75 `Tick`s → display 01:15, `Running`=1, `Lap_Active`=0.
- RUN at 00:09, then `Lap` → display frozen at 00:09 while live time advances over 5 `Tick`s. Then `Lap` → display 00:14 immediately.
- RUN at 59:59 (MIN_MOD=60), then `Tick` → display 00:00, `Wrap` high one cycle, still RUN. Repeat with MIN_MOD=100: 99:59 → 00:00.
- `Clear` while RUN at 00:30 → ignored. `Start_Stop` → PAUSE at 00:30. `Clear` and `Start_Stop` on the same edge → IDLE, 00:00, `Running`=0.
- `Start_Stop` coincident with `Tick` in RUN at 00:05 → PAUSE showing 00:06. In PAUSE, coincident `Start_Stop`+`Tick` → RUN still showing 00:06.
- `Reset_n` pulsed low between edges while in LAP at 02:41 → all outputs 0 and IDLE before the next edge. A subsequent `Tick` leaves 00:00.

Source files
------------

// File: rtl/stopwatch_core_pkg.sv
// Shared constants and types for the MM:SS BCD stopwatch: FSM encodings,
// BCD digit width and the seconds-tens limit.
package stopwatch_core_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_LAP   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One modulo-N BCD digit with synchronous clear and a combinational carry
// that lets digits be chained Carry -> Inc.
module bcd_digit
    import stopwatch_core_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Inc,
    input  logic             Clr,
    output logic [BCD_W-1:0] Digit,
    output logic             Carry
);

    localparam logic [BCD_W-1:0] MAX_VAL = BCD_W'(MODULUS - 1);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (Clr) begin
            digit_d = '0;
        end else if (Inc) begin
            digit_d = (digit_q == MAX_VAL) ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign Digit = digit_q;
    assign Carry = Inc && (digit_q == MAX_VAL);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch top: start/stop/lap/clear controller, four chained BCD digits,
// a lap latch and the live/lap display mux.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int MIN_MOD = 60
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Tick,
    input  logic             Start_Stop,
    input  logic             Lap,
    input  logic             Clear,
    output logic [BCD_W-1:0] Sec_Ones,
    output logic [BCD_W-1:0] Sec_Tens,
    output logic [BCD_W-1:0] Min_Ones,
    output logic [BCD_W-1:0] Min_Tens,
    output logic             Running,
    output logic             Lap_Active,
    output logic             Wrap
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    bcd_time_t  live;
    bcd_time_t  lap_q;
    bcd_time_t  lap_d;
    logic       wrap_q;
    logic       capture;
    logic       clear_time;
    logic       count_en;
    logic       c_so;
    logic       c_st;
    logic       c_mo;
    logic       c_mt;

    // Only the highest-priority pulse present acts, even if the state ignores it.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        clear_time = 1'b0;
        if (Clear) begin
            if (state_q == ST_PAUSE) begin
                state_d    = ST_IDLE;
                clear_time = 1'b1;
            end
        end else if (Start_Stop) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_LAP:   state_d = ST_PAUSE;
                default:  state_d = ST_RUN;
            endcase
        end else if (Lap) begin
            if (state_q == ST_RUN) begin
                state_d = ST_LAP;
                capture = 1'b1;
            end else if (state_q == ST_LAP) begin
                state_d = ST_RUN;
            end
        end
    end

    assign count_en = Tick && ((state_q == ST_RUN) || (state_q == ST_LAP));

    bcd_digit #(.MODULUS(10)) u_sec_ones (
        .Clock(Clock), .Reset_n(Reset_n), .Inc(count_en), .Clr(clear_time),
        .Digit(live.sec_ones), .Carry(c_so)
    );
    bcd_digit #(.MODULUS(SEC_TENS_MAX + 1)) u_sec_tens (
        .Clock(Clock), .Reset_n(Reset_n), .Inc(c_so), .Clr(clear_time),
        .Digit(live.sec_tens), .Carry(c_st)
    );
    bcd_digit #(.MODULUS(10)) u_min_ones (
        .Clock(Clock), .Reset_n(Reset_n), .Inc(c_st), .Clr(clear_time),
        .Digit(live.min_ones), .Carry(c_mo)
    );
    bcd_digit #(.MODULUS(MIN_MOD / 10)) u_min_tens (
        .Clock(Clock), .Reset_n(Reset_n), .Inc(c_mo), .Clr(clear_time),
        .Digit(live.min_tens), .Carry(c_mt)
    );

    // Capture uses the pre-increment live value when a Tick lands on the same edge.
    always_comb begin
        lap_d = lap_q;
        if (clear_time) begin
            lap_d = '0;
        end else if (capture) begin
            lap_d = live;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            wrap_q  <= c_mt;
        end
    end

    assign Running    = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign Lap_Active = (state_q == ST_LAP);
    assign Wrap       = wrap_q;

    assign Sec_Ones = (state_q == ST_LAP) ? lap_q.sec_ones : live.sec_ones;
    assign Sec_Tens = (state_q == ST_LAP) ? lap_q.sec_tens : live.sec_tens;
    assign Min_Ones = (state_q == ST_LAP) ? lap_q.min_ones : live.min_ones;
    assign Min_Tens = (state_q == ST_LAP) ? lap_q.min_tens : live.min_tens;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: two instances (MIN_MOD 60 and 100) share stimulus.
module tb_stopwatch_core;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Tick = 1'b0;
    logic       Start_Stop = 1'b0;
    logic       Lap = 1'b0;
    logic       Clear = 1'b0;

    logic [3:0] so60, st60, mo60, mt60;
    logic [3:0] so100, st100, mo100, mt100;
    logic       run60, lapa60, wrap60;
    logic       run100, lapa100, wrap100;

    int tests = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    stopwatch_core #(.MIN_MOD(60)) dut60 (
        .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Start_Stop(Start_Stop),
        .Lap(Lap), .Clear(Clear),
        .Sec_Ones(so60), .Sec_Tens(st60), .Min_Ones(mo60), .Min_Tens(mt60),
        .Running(run60), .Lap_Active(lapa60), .Wrap(wrap60)
    );

    stopwatch_core #(.MIN_MOD(100)) dut100 (
        .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Start_Stop(Start_Stop),
        .Lap(Lap), .Clear(Clear),
        .Sec_Ones(so100), .Sec_Tens(st100), .Min_Ones(mo100), .Min_Tens(mt100),
        .Running(run100), .Lap_Active(lapa100), .Wrap(wrap100)
    );

    wire [15:0] disp60  = {mt60, mo60, st60, so60};
    wire [15:0] disp100 = {mt100, mo100, st100, so100};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of pulses at a falling edge; outputs are settled at the next falling edge.
    task automatic step(input logic t, input logic ss, input logic lp, input logic cl);
        @(negedge Clock);
        Tick = t; Start_Stop = ss; Lap = lp; Clear = cl;
        @(negedge Clock);
        Tick = 1'b0; Start_Stop = 1'b0; Lap = 1'b0; Clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset_disp60", disp60, 16'h0000);
        chk("reset_disp100", disp100, 16'h0000);
        chk("reset_running", {15'd0, run60}, 16'd0);
        chk("reset_lap", {15'd0, lapa60}, 16'd0);
        chk("reset_wrap", {15'd0, wrap60}, 16'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Start, 75 ticks -> 01:15
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_running", {15'd0, run60}, 16'd1);
        ticks(75);
        chk("count75_disp", disp60, 16'h0115);
        chk("count75_running", {15'd0, run60}, 16'd1);
        chk("count75_lap", {15'd0, lapa60}, 16'd0);

        // Lap freeze at 00:09
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(9);
        chk("pre_lap_disp", disp60, 16'h0009);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_active", {15'd0, lapa60}, 16'd1);
        chk("lap_running", {15'd0, run60}, 16'd1);
        chk("lap_disp", disp60, 16'h0009);
        ticks(5);
        chk("lap_frozen", disp60, 16'h0009);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_release_disp", disp60, 16'h0014);
        chk("lap_release_flag", {15'd0, lapa60}, 16'd0);
        // Lap and Tick together latch the pre-increment value
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("lap_tick_latch", disp60, 16'h0014);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_tick_live", disp60, 16'h0015);

        // Clear ignored in RUN, then pause, then clear+start -> IDLE
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(30);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_in_run_disp", disp60, 16'h0030);
        chk("clear_in_run_running", {15'd0, run60}, 16'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_running", {15'd0, run60}, 16'd0);
        chk("pause_disp", disp60, 16'h0030);
        ticks(2);
        chk("pause_no_count", disp60, 16'h0030);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clear_disp", disp60, 16'h0000);
        chk("clear_running", {15'd0, run60}, 16'd0);
        ticks(1);
        chk("idle_no_count", disp60, 16'h0000);

        // Start_Stop coincident with Tick
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ss_tick_run_disp", disp60, 16'h0006);
        chk("ss_tick_run_state", {15'd0, run60}, 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ss_tick_pause_disp", disp60, 16'h0006);
        chk("ss_tick_pause_state", {15'd0, run60}, 16'd1);
        ticks(1);
        chk("resume_count", disp60, 16'h0007);

        // Asynchronous reset in LAP at 02:41
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(161);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap241_disp", disp60, 16'h0241);
        chk("lap241_flag", {15'd0, lapa60}, 16'd1);
        @(posedge Clock);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst_disp", disp60, 16'h0000);
        chk("async_rst_running", {15'd0, run60}, 16'd0);
        chk("async_rst_lap", {15'd0, lapa60}, 16'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        ticks(1);
        chk("post_rst_tick", disp60, 16'h0000);

        // Wrap at 59:59 for MIN_MOD=60
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3599);
        chk("pre_wrap60", disp60, 16'h5959);
        chk("pre_wrap60_flag", {15'd0, wrap60}, 16'd0);
        ticks(1);
        chk("wrap60_disp", disp60, 16'h0000);
        chk("wrap60_flag", {15'd0, wrap60}, 16'd1);
        chk("wrap60_running", {15'd0, run60}, 16'd1);
        @(negedge Clock);
        chk("wrap60_one_cycle", {15'd0, wrap60}, 16'd0);
        ticks(1);
        chk("wrap60_continue", disp60, 16'h0001);

        // Wrap at 99:59 for MIN_MOD=100
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5999);
        chk("pre_wrap100", disp100, 16'h9959);
        ticks(1);
        chk("wrap100_disp", disp100, 16'h0000);
        chk("wrap100_flag", {15'd0, wrap100}, 16'd1);
        chk("wrap100_running", {15'd0, run100}, 16'd1);
        @(negedge Clock);
        chk("wrap100_one_cycle", {15'd0, wrap100}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
